// File: rtl/vga_sync_monitor_if.sv
// Signal bundle between a VGA raster source and vga_sync_monitor.
// err_count exists only when VGA_MON_ERRCNT_EN is defined.
interface vga_sync_monitor_if;
    logic       pixel_tick;
    logic       hsync;
    logic       vsync;
    logic       err_clr;
    logic       locked;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       frame_start;
    logic       err_hline;
    logic       err_hpulse;
    logic       err_vframe;
    logic       err_vpulse;
`ifdef VGA_MON_ERRCNT_EN
    logic [7:0] err_count;

    modport master (
        output pixel_tick, hsync, vsync, err_clr,
        input  locked, pixel_x, pixel_y, video_on, frame_start,
        input  err_hline, err_hpulse, err_vframe, err_vpulse, err_count
    );
    modport slave (
        input  pixel_tick, hsync, vsync, err_clr,
        output locked, pixel_x, pixel_y, video_on, frame_start,
        output err_hline, err_hpulse, err_vframe, err_vpulse, err_count
    );
`else
    modport master (
        output pixel_tick, hsync, vsync, err_clr,
        input  locked, pixel_x, pixel_y, video_on, frame_start,
        input  err_hline, err_hpulse, err_vframe, err_vpulse
    );
    modport slave (
        input  pixel_tick, hsync, vsync, err_clr,
        output locked, pixel_x, pixel_y, video_on, frame_start,
        output err_hline, err_hpulse, err_vframe, err_vpulse
    );
`endif
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers raster position, locks, flags errors.
// Define VGA_MON_ERRCNT_EN to add the saturating err_count output.
module vga_sync_monitor #(
    parameter int HD          = 640,
    parameter int HF          = 16,
    parameter int HB          = 48,
    parameter int HR          = 96,
    parameter int VD          = 480,
    parameter int VF          = 10,
    parameter int VB          = 33,
    parameter int VR          = 2,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_POL    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_sync_monitor_if.slave bus
);
    localparam int H_TOTAL = HD + HF + HB + HR;
    localparam int V_TOTAL = VD + VF + VB + VR;

    localparam logic [10:0] H_END  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_MAX  = 11'h7FF;
    localparam logic [10:0] HR_END = 11'(HR - 1);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
    localparam logic [9:0]  VR_L   = 10'(VR);
    localparam logic [9:0]  PX_END = 10'(H_TOTAL - 1);
    localparam logic [9:0]  PY_END = 10'(V_TOTAL - 1);
    localparam logic [9:0]  PX_SYN = 10'(HD + HF);
    localparam logic [9:0]  PY_SYN = 10'(VD + VF);
    localparam logic [9:0]  HD_L   = 10'(HD);
    localparam logic [9:0]  VD_L   = 10'(VD);
    localparam logic [3:0]  LOCK_L = 4'(LOCK_FRAMES);
    localparam logic        INACT  = (SYNC_POL != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    function automatic logic act(input logic s);
        return (SYNC_POL != 0) ? s : ~s;
    endfunction

    state_t      state_q, state_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [9:0]  px_q, px_d, py_q, py_d;
    logic [3:0]  good_q, good_d;
    logic        dirty_q, dirty_d;
    logic        locked_q, locked_d;
    logic        vo_q, vo_d;
    logic        fs_q, fs_d;
    logic        e_hl_q, e_hl_d, e_hp_q, e_hp_d;
    logic        e_vf_q, e_vf_d, e_vp_q, e_vp_d;
    logic        ev_hl, ev_hp, ev_vf, ev_vp, ev_lost, ev_any;
    logic        wrap;
    logic [9:0]  v_chk;
    logic        tick, h_lead, h_trail, v_lead, v_trail;

    assign tick    = bus.pixel_tick;
    assign h_lead  = tick & act(bus.hsync) & ~act(hs_q);
    assign h_trail = tick & ~act(bus.hsync) & act(hs_q);
    assign v_lead  = tick & act(bus.vsync) & ~act(vs_q);
    assign v_trail = tick & ~act(bus.vsync) & act(vs_q);

`ifdef VGA_MON_ERRCNT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        px_d    = px_q;
        py_d    = py_q;
        ev_hl   = 1'b0;
        ev_hp   = 1'b0;
        ev_vf   = 1'b0;
        ev_vp   = 1'b0;
        ev_lost = 1'b0;
        wrap    = 1'b0;
        v_chk   = h_lead ? v_cnt_q + 10'd1 : v_cnt_q;
        if (tick) begin
            hs_d = bus.hsync;
            vs_d = bus.vsync;
            if (h_lead) begin
                ev_hl   = (state_q != SEARCH) && (h_cnt_q != H_END);
                h_cnt_d = '0;
            end else if (h_cnt_q != H_MAX) begin
                h_cnt_d = h_cnt_q + 11'd1;
                ev_lost = (h_cnt_q == H_MAX - 11'd1);
            end
            ev_hp = h_trail && (h_cnt_q != HR_END);
            if (v_lead) begin
                ev_vf   = (v_chk != V_TOT);
                v_cnt_d = '0;
            end else if (h_lead) begin
                v_cnt_d = v_chk;
            end
            ev_vp = v_trail && (v_cnt_q != VR_L);
            if (h_lead) begin
                px_d = PX_SYN;
            end else if (px_q == PX_END) begin
                px_d = '0;
                wrap = 1'b1;
            end else begin
                px_d = px_q + 10'd1;
            end
            if (v_lead) begin
                py_d = PY_SYN;
            end else if (wrap) begin
                py_d = (py_q == PY_END) ? 10'd0 : py_q + 10'd1;
            end
        end
        ev_any  = ev_hl | ev_hp | ev_vf | ev_vp | ev_lost;
        // sticky flags: a new event beats a same-edge clear
        e_hl_d  = (e_hl_q & ~bus.err_clr) | ev_hl | ev_lost;
        e_hp_d  = (e_hp_q & ~bus.err_clr) | ev_hp;
        e_vf_d  = (e_vf_q & ~bus.err_clr) | ev_vf;
        e_vp_d  = (e_vp_q & ~bus.err_clr) | ev_vp;
        dirty_d = v_lead ? 1'b0 : (dirty_q | ev_any);

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (v_lead) begin
                    state_d = ALIGN;
                    good_d  = '0;
                end
            end
            ALIGN: begin
                if (ev_any) begin
                    good_d = '0;
                end else if (v_lead && !dirty_q) begin
                    good_d = good_q + 4'd1;
                    if (good_d >= LOCK_L) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (ev_any) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
        if (ev_lost) begin
            state_d = SEARCH;
            good_d  = '0;
        end
        locked_d = (state_d == LOCKED);
        vo_d     = locked_d && (px_d < HD_L) && (py_d < VD_L);
        fs_d     = v_lead;
`ifdef VGA_MON_ERRCNT_EN
        if (ev_any) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (bus.err_clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            hs_q     <= INACT;
            vs_q     <= INACT;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            px_q     <= '0;
            py_q     <= '0;
            good_q   <= '0;
            dirty_q  <= 1'b0;
            locked_q <= 1'b0;
            vo_q     <= 1'b0;
            fs_q     <= 1'b0;
            e_hl_q   <= 1'b0;
            e_hp_q   <= 1'b0;
            e_vf_q   <= 1'b0;
            e_vp_q   <= 1'b0;
`ifdef VGA_MON_ERRCNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            px_q     <= px_d;
            py_q     <= py_d;
            good_q   <= good_d;
            dirty_q  <= dirty_d;
            locked_q <= locked_d;
            vo_q     <= vo_d;
            fs_q     <= fs_d;
            e_hl_q   <= e_hl_d;
            e_hp_q   <= e_hp_d;
            e_vf_q   <= e_vf_d;
            e_vp_q   <= e_vp_d;
`ifdef VGA_MON_ERRCNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.locked      = locked_q;
    assign bus.pixel_x     = px_q;
    assign bus.pixel_y     = py_q;
    assign bus.video_on    = vo_q;
    assign bus.frame_start = fs_q;
    assign bus.err_hline   = e_hl_q;
    assign bus.err_hpulse  = e_hp_q;
    assign bus.err_vframe  = e_vf_q;
    assign bus.err_vpulse  = e_vp_q;
`ifdef VGA_MON_ERRCNT_EN
    assign bus.err_count   = cnt_q;
`endif
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side checker for the VGA raster produced by vga_sync. Samples hsync/vsync on each pixel tick.
- Measures line, frame and pulse timing against 640x480 parameters.
- Recovers pixel_x/pixel_y and video_on, locks after clean frames, and reports sticky timing errors.
- Sits beside vga_sync in benches and on board, to self-check the sync generator.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch
- HB, 48, horizontal back porch
- HR, 96, hsync pulse width (ticks)
- VD, 480, vertical display lines
- VF, 10, vertical front porch
- VB, 33, vertical back porch
- VR, 2, vsync pulse width (lines)
- LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15)
- SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- pixel_tick  in  1  pixel enable; all sampling and counting happen only on clk edges with pixel_tick=1
- hsync  in  1  horizontal sync under test
- vsync  in  1  vertical sync under test
- err_clr  in  1  clears sticky error flags
- locked  out  1  timing matches parameters
- pixel_x  out  10  recovered column of the pixel sampled on the last tick
- pixel_y  out  10  recovered row
- video_on  out  1  locked && pixel_x<HD && pixel_y<VD
- frame_start  out  1  one-clk pulse on the tick that detects a vsync leading edge
- err_hline  out  1  sticky: line length != H_TOTAL, or hsync lost
- err_hpulse  out  1  sticky: hsync width != HR
- err_vframe  out  1  sticky: frame length != V_TOTAL
- err_vpulse  out  1  sticky: vsync width != VR

Behaviour:
- Totals: H_TOTAL = HD+HF+HB+HR = 800; V_TOTAL = VD+VF+VB+VR = 525.
- Reset (reset_n=0 at clk edge):
  - all outputs 0; state SEARCH; h_cnt=0, v_cnt=0, good_cnt=0.
  - Sync sample registers hs_q/vs_q take the inactive level, so there is no false edge after reset.
  - Reset takes priority over everything, including mid-frame.
- On each tick, hs_q<=hsync and vs_q<=vsync.
  - Leading edge = hs_q inactive and hsync active, using SYNC_POL. Trailing edge = the reverse. Same rule for vsync.
- h_cnt (11 bit):
  - On an hsync leading edge: check pre-update h_cnt==H_TOTAL-1, else set err_hline; then h_cnt<=0. The check is skipped while in SEARCH.
  - Otherwise, on each tick, h_cnt increments.
  - On an hsync trailing edge: check h_cnt==HR-1, else set err_hpulse.
  - h_cnt saturating at 2047 means hsync is lost: set err_hline and go to SEARCH.
- v_cnt (10 bit):
  - Increments on each hsync leading edge.
  - On a vsync leading edge: check v_cnt==V_TOTAL, else set err_vframe; then v_cnt<=0.
  - If the vsync and hsync leading edges fall on the same tick, check v_cnt+1 and clear v_cnt to 0.
  - On a vsync trailing edge: check v_cnt==VR, else set err_vpulse.
- pixel_x, on each tick:
  - hsync leading edge: pixel_x<=HD+HF.
  - Otherwise it increments, wrapping from H_TOTAL-1 to 0.
- pixel_y, on each tick:
  - vsync leading edge: pixel_y<=VD+VF. This has priority over the wrap increment.
  - Otherwise it increments on each pixel_x wrap, wrapping from V_TOTAL-1 to 0.
- Error flags:
  - Set on the clk after the detecting tick.
  - Cleared by err_clr=1; if set and clear happen on the same edge, set wins.
  - Not cleared by loss of lock.
- FSM:
  - SEARCH: on the first vsync leading edge go to ALIGN with good_cnt=0.
  - ALIGN: any error event clears good_cnt. A vsync leading edge with no error event since the previous one increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED (locked=1 next clk).
  - LOCKED: any error event goes to SEARCH (locked=0 next clk).
- Error events are checked in all states except the SEARCH-skipped line check.

Optional Feature:
- Macro VGA_MON_ERRCNT_EN.
- Defined: adds output err_count (8 bit).
  - Increments once per clk in which at least one error flag sets.
  - Saturates at 255; cleared by err_clr (increment wins on a same-edge collision); reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Golden lock: vga_sync model, pixel_tick every 2nd clk, 4 frames.
  - locked rises 1 clk after the 3rd vsync leading edge.
  - After that, pixel_x/pixel_y equal the model counters every tick; no error flags.
- Short line: one line of 799 ticks.
  - err_hline=1; locked falls next clk; relock after the vsync edge plus 2 clean frames.
  - err_hpulse stays 0.
- Pulse errors:
  - hsync width 95 sets err_hpulse.
  - vsync width 3 lines sets err_vpulse.
  - A frame of 524 lines sets err_vframe.
  - err_clr then clears all flags.
- Lost sync: hsync stuck inactive for 2048 ticks.
  - err_hline=1 and state SEARCH.
  - With VGA_MON_ERRCNT_EN, err_count=1.
- Reset mid-frame: reset_n=0 for 1 clk at pixel (300,200).
  - All outputs 0 next clk; no lock until 3 further vsync leading edges.
- Clear collision: err_clr=1 on the same edge as a new err_hpulse.
  - err_hpulse=1 after that edge.
  - err_count saturates at 255 after 300 forced errors.
